// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Instruction fetches always read a full 32-bit word.
    localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One transaction at a time; data wins by default, but fetch is forced
// through after MAX_D_STREAK back-to-back data grants so it cannot starve.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [31:0]   m_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    state;
    arb_owner_t    owner;
    logic [SW-1:0] streak;
    logic          win_if;
    logic          capture;

    // Fetch wins when data is absent or data has used up its streak allowance.
    assign win_if = if_req & (~d_req | (streak == STREAK_MAX));

    // Response data is taken either together with the grant or later in WAIT.
    assign capture = ((state == ISSUE) & m_gnt & m_rvalid) |
                     ((state == WAIT) & m_rvalid);

    // Transaction FSM, owner latch and fetch-starvation streak counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= IDLE;
            owner  <= OWN_IF;
            streak <= '0;
        end else begin
            if (!if_req) begin
                streak <= '0;
            end else if (state == IDLE) begin
                if (win_if) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (if_req | d_req) begin
                        owner <= win_if ? OWN_IF : OWN_D;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_gnt) begin
                        state <= m_rvalid ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-owner read data; holds until that owner's next completion.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (capture) begin
            if (owner == OWN_IF) begin
                if_rdata <= m_rdata;
            end else begin
                d_rdata <= m_rdata;
            end
        end
    end

    // Memory request fields are steered from the owner only while issuing.
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (state == ISSUE) begin
            m_req = 1'b1;
            if (owner == OWN_IF) begin
                m_be   = FETCH_BE;
                m_addr = if_addr;
            end else begin
                m_we    = d_we;
                m_be    = d_be;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
        end
    end

    assign if_done   = (state == RESP) & (owner == OWN_IF);
    assign d_done    = (state == RESP) & (owner == OWN_D);
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and
// the memory, driving inputs 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        stall_if;
    logic        stall_mem;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected grant order under starvation: 1 = fetch, 0 = data.
    logic [9:0] starve_exp;

    mem_port_arbiter #(.AW(32), .MAX_D_STREAK(4)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTn = 1'b0; if_req = 1'b1; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        #2;
        // Reset values; stall follows its request even in reset.
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_be", 32'(m_be), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_done", 32'({if_done, d_done}), 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        chk("rst_stall_if", 32'(stall_if), 32'd1);
        if_req = 1'b0;
        #1;
        chk("rst_stall_if_low", 32'(stall_if), 32'd0);
        tick(); tick();
        RSTn = 1'b1;

        // Lone fetch: req at cycle 0, grant at 1, rvalid at 2, done at 3.
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        chk("fetch_c0_stall", 32'(stall_if), 32'd1);
        chk("fetch_c0_m_req", 32'(m_req), 32'd0);
        tick();
        m_gnt = 1'b1;
        chk("fetch_c1_m_req", 32'(m_req), 32'd1);
        chk("fetch_c1_m_be", 32'(m_be), 32'hF);
        chk("fetch_c1_m_addr", m_addr, 32'h100);
        chk("fetch_c1_m_we", 32'(m_we), 32'd0);
        tick();
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0013;
        chk("fetch_c2_m_req", 32'(m_req), 32'd0);
        chk("fetch_c2_if_done", 32'(if_done), 32'd0);
        chk("fetch_c2_stall", 32'(stall_if), 32'd1);
        tick();
        m_rvalid = 1'b0; m_rdata = 32'hFFFF_FFFF;
        chk("fetch_c3_if_done", 32'(if_done), 32'd1);
        chk("fetch_c3_if_rdata", if_rdata, 32'h0000_0013);
        chk("fetch_c3_stall", 32'(stall_if), 32'd0);
        if_req = 1'b0;
        tick();
        chk("fetch_c4_if_done", 32'(if_done), 32'd0);
        chk("fetch_c4_hold", if_rdata, 32'h0000_0013);

        // Contention: store wins first, fetch issues 2 cycles after RESP.
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hBEEF;
        tick();
        chk("cont_m_req", 32'(m_req), 32'd1);
        chk("cont_m_we", 32'(m_we), 32'd1);
        chk("cont_m_be", 32'(m_be), 32'b0011);
        chk("cont_m_addr", m_addr, 32'h2004);
        chk("cont_m_wdata", m_wdata, 32'hBEEF);
        chk("cont_stall_mem", 32'(stall_mem), 32'd1);
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
        tick();
        m_gnt = 1'b0; m_rvalid = 1'b0;
        chk("cont_d_done", 32'(d_done), 32'd1);
        chk("cont_if_done_low", 32'(if_done), 32'd0);
        chk("cont_stall_mem_low", 32'(stall_mem), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("cont_idle_m_req", 32'(m_req), 32'd0);
        tick();
        chk("cont_if_m_req", 32'(m_req), 32'd1);
        chk("cont_if_m_addr", m_addr, 32'h200);
        chk("cont_if_m_be", 32'(m_be), 32'hF);
        chk("cont_if_m_we", 32'(m_we), 32'd0);
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0000_0093;
        tick();
        m_gnt = 1'b0; m_rvalid = 1'b0;
        chk("cont_if_done", 32'(if_done), 32'd1);
        chk("cont_if_rdata", if_rdata, 32'h0000_0093);
        if_req = 1'b0;
        tick();

        // Starvation: fetch forced through after 4 data grants, then streak restarts.
        starve_exp = 10'b10000_10000;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400;
        for (int i = 0; i < 10; i++) begin
            logic is_if;
            for (int k = 0; k < 8 && !m_req; k++) tick();
            chk($sformatf("starve_grant_%0d", i), 32'(m_req), 32'd1);
            is_if = (m_addr == 32'h300);
            chk($sformatf("starve_owner_%0d", i), 32'(is_if), 32'(starve_exp[i]));
            m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hA000_0000 + 32'(i);
            tick();
            m_gnt = 1'b0; m_rvalid = 1'b0;
            chk($sformatf("starve_done_%0d", i), 32'(is_if ? if_done : d_done), 32'd1);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("starve_d_rdata", d_rdata, 32'hA000_0008);
        chk("starve_if_rdata", if_rdata, 32'hA000_0009);
        tick();

        // Grant backpressure with a spurious rvalid during ISSUE.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        tick();
        for (int i = 0; i < 5; i++) begin
            m_rvalid = (i == 2); m_rdata = 32'hBAD0_0BAD;
            #1;
            chk($sformatf("bp_m_req_%0d", i), 32'(m_req), 32'd1);
            chk($sformatf("bp_m_addr_%0d", i), m_addr, 32'h80);
            tick();
        end
        chk("bp_no_done", 32'(d_done), 32'd0);
        chk("bp_rdata_hold", d_rdata, 32'hA000_0008);
        m_rvalid = 1'b0; m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        chk("bp_wait_m_req", 32'(m_req), 32'd0);
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        tick();
        m_rvalid = 1'b0;
        chk("bp_d_done", 32'(d_done), 32'd1);
        chk("bp_d_rdata", d_rdata, 32'h1234_5678);
        d_req = 1'b0;
        tick();

        // Same-cycle grant and rvalid: done the very next cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        tick();
        chk("fast_m_addr", m_addr, 32'h40);
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        tick();
        m_gnt = 1'b0; m_rvalid = 1'b0;
        chk("fast_d_done", 32'(d_done), 32'd1);
        chk("fast_d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();
        chk("fast_d_done_once", 32'(d_done), 32'd0);

        // Reset while in WAIT, then a late rvalid.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h60; d_wdata = 32'h77;
        tick();
        m_gnt = 1'b1;
        tick();
        m_gnt = 1'b0;
        chk("rw_in_wait", 32'(m_req), 32'd0);
        RSTn = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("rw_async_rdata", if_rdata | d_rdata, 32'd0);
        chk("rw_async_m", 32'({m_req, m_we, m_be}), 32'd0);
        tick();
        RSTn = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'hBAD;
        tick();
        m_rvalid = 1'b0;
        chk("rw_late_no_done", 32'({if_done, d_done}), 32'd0);
        chk("rw_late_m_req", 32'(m_req), 32'd0);
        chk("rw_late_rdata", d_rdata, 32'd0);
        tick();
        chk("rw_idle_m_req", 32'(m_req), 32'd0);
        chk("rw_idle_m_addr", m_addr, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the pipelined RISC-V core between the instruction-fetch (IF) stage and the data-access (MEM) stage. Each requester holds a level request until a one-cycle done pulse. The arbiter drives one request/grant/response transaction on the memory port at a time. It generates the IF and MEM stall signals consumed by the pipeline hazard logic.

## Interface
Parameters:
- AW, 32: byte-address width.
- MAX_D_STREAK, 4: consecutive data grants allowed while IF waits before IF is forced to win (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request, held until if_done.
- if_addr  in  AW  fetch address, stable while if_req.
- if_rdata  out  32  fetched instruction, valid with if_done.
- if_done  out  1  one-cycle completion pulse.
- d_req  in  1  data request (MemRead|MemWrite), held until d_done.
- d_we  in  1  write when 1.
- d_be  in  4  byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, valid with d_done.
- d_done  out  1  one-cycle completion pulse.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_be  out  4  memory byte enables.
- m_addr  out  AW  memory address.
- m_wdata  out  32  memory write data.
- m_gnt  in  1  memory accepted the request this cycle.
- m_rvalid  in  1  transaction complete (read data or write ack).
- m_rdata  in  32  memory read data.
- stall_if  out  1  = if_req & ~if_done.
- stall_mem  out  1  = d_req & ~d_done.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. An owner register records IF or D.
- IDLE: if any request is pending, pick a winner, latch owner, and go to ISSUE. Otherwise stay.
- Arbitration: D wins by default. IF wins when d_req=0, or when streak == MAX_D_STREAK and if_req=1.
- Streak counter:
  - Increments on each D grant while if_req=1, saturating at MAX_D_STREAK.
  - Clears on any IF grant, or in any cycle with if_req=0.
- ISSUE: m_req=1. m_addr/m_we/m_be/m_wdata come combinationally from the owner's inputs.
  - IF owner: we=0, be=4'b1111, wdata=0.
  - Stay while m_gnt=0.
  - m_gnt=1 and m_rvalid=0 → WAIT. m_gnt=1 and m_rvalid=1 → RESP.
- WAIT: m_req=0. m_rvalid=1 → RESP, capturing m_rdata into the owner's rdata register.
- RESP: the owner's done=1 for exactly one cycle, then → IDLE. The requester drops or renews req at that same edge.
- m_rvalid in IDLE or RESP, or m_gnt outside ISSUE: ignored, no state change.
- Writes complete on m_rvalid exactly like reads. d_rdata is updated on writes too; its content is don't-care.
- if_rdata/d_rdata hold their last captured value until the next completion for that owner.
- Requester inputs changing while not owner: no effect. A requester must not drop req mid-transaction. If it does, the transaction still completes and done still pulses.

## Timing
- Reset (RSTn=0, asynchronous): state=IDLE, streak=0, m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0. stall outputs follow inputs.
- Reset mid-transaction abandons it. A late m_rvalid arriving in IDLE is ignored.
- Minimum latency: req at cycle 0; m_req at 1 with m_gnt; m_rvalid at 2; done at 3. m_gnt and m_rvalid both at 1 gives done at 2.
- Back-to-back: a new transaction's ISSUE begins at the earliest 2 cycles after RESP (RESP→IDLE→ISSUE).
- Simultaneous if_req and d_req in IDLE: D granted unless the streak is saturated.
- stall_if/stall_mem are combinational. All other outputs are registered state or state-decoded.

## Structure
- Package mem_arb_pkg holds:
  - The state enum (IDLE, ISSUE, WAIT, RESP).
  - The owner encoding (OWN_IF, OWN_D).
  - The constant FETCH_BE = 4'b1111.
- Single module, no sub-modules. The streak counter width is $clog2(MAX_D_STREAK+1).

## Test plan
- Lone fetch: if_req, addr 0x100, m_gnt immediate, m_rvalid next cycle with 0x00000013 → m_req/m_be=1111 at cycle 1, if_done and if_rdata=0x00000013 at cycle 3, stall_if high cycles 0–2.
- Contention: if_req and d_req (store, be=0011, addr 0x2004, wdata 0xBEEF) in the same cycle → data issued first with m_we=1, m_be=0011. IF is issued after d_done, exactly 2 cycles after RESP.
- Starvation: if_req held, d_req renewed continuously, MAX_D_STREAK=4 → exactly 4 data grants, then an IF grant, then the streak restarts at 0.
- Grant backpressure: m_gnt held low 5 cycles → m_req stays high and address stable 5 cycles. A spurious m_rvalid during ISSUE without m_gnt is ignored.
- Same-cycle gnt+rvalid on a load at 0x40 returning 0xDEADBEEF → d_done one cycle later, with no WAIT state visited.
- Reset in WAIT: RSTn low for 1 cycle, then m_rvalid arrives → all outputs at reset values, no done pulse, FSM stays in IDLE.
